alu_issue_ctrl: RTL

//  Drives the data-processing ALU: accepts ARM DP instruction words (valid/ready), reads Rn/Rm, builds operand2,

---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/alu_issue_ctrl_cond_check.sv | 49 ++++
 rtl/alu_issue_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the data-processing ALU and its issue controller:
//   - ALU opcode constants (codebase encoding, 0x00..0x0E plus SHIFT at 0x13)
//   - flag bit indices into a 4-bit NZCV vector ([0]N [1]Z [2]C [3]V)
//   - ARM data-processing opcode and condition-code enums
//   - issue controller state enum
//   - small helpers: 32-bit rotate-right and ARM-op -> ALU-opcode mapping
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] ALU_AND   = 5'h00;
    localparam logic [4:0] ALU_EOR   = 5'h01;
    localparam logic [4:0] ALU_SUB   = 5'h02;
    localparam logic [4:0] ALU_RSB   = 5'h03;
    localparam logic [4:0] ALU_ADD   = 5'h04;
    localparam logic [4:0] ALU_ADC   = 5'h05;
    localparam logic [4:0] ALU_SBC   = 5'h06;
    localparam logic [4:0] ALU_RSC   = 5'h07;
    localparam logic [4:0] ALU_TST   = 5'h08;
    localparam logic [4:0] ALU_TEQ   = 5'h09;
    localparam logic [4:0] ALU_CMP   = 5'h0A;
    localparam logic [4:0] ALU_CMN   = 5'h0B;
    localparam logic [4:0] ALU_ORR   = 5'h0C;
    localparam logic [4:0] ALU_BIC   = 5'h0D;
    localparam logic [4:0] ALU_MVN   = 5'h0E;
    localparam logic [4:0] ALU_SHIFT = 5'h13;

    // Bit positions inside any NZCV vector (alu_flags, cpsr_flags).
    localparam int NEG = 0;
    localparam int ZER = 1;
    localparam int CAR = 2;
    localparam int OVR = 3;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic [3:0] {
        DP_AND = 4'h0, DP_EOR = 4'h1, DP_SUB = 4'h2, DP_RSB = 4'h3,
        DP_ADD = 4'h4, DP_ADC = 4'h5, DP_SBC = 4'h6, DP_RSC = 4'h7,
        DP_TST = 4'h8, DP_TEQ = 4'h9, DP_CMP = 4'hA, DP_CMN = 4'hB,
        DP_ORR = 4'hC, DP_MOV = 4'hD, DP_BIC = 4'hE, DP_MVN = 4'hF
    } dp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Rotate right by 0..31; duplicating the word lets one shift do the wrap.
    function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {val, val} >> amt;
        return dbl[31:0];
    endfunction

    // ARM ops 0..C map straight through; MOV reuses ORR with a zero a-operand.
    function automatic logic [4:0] map_opcode(input logic [3:0] op);
        logic [4:0] code;
        case (op)
            DP_MOV:  code = ALU_ORR;
            DP_BIC:  code = ALU_BIC;
            DP_MVN:  code = ALU_MVN;
            default: code = {1'b0, op};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Combinational ARM condition-code evaluator.
//   cond_i [3:0]  condition field of the instruction
//   nzcv_i [3:0]  current flags, [0]N [1]Z [2]C [3]V
//   pass_o        1 when the instruction should execute
// -----------------------------------------------------------------------------
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = nzcv_i[NEG];
    assign z_s = nzcv_i[ZER];
    assign c_s = nzcv_i[CAR];
    assign v_s = nzcv_i[OVR];

    // Condition table; NV (1111) never executes.
    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z_s;
            COND_NE: pass_o = ~z_s;
            COND_CS: pass_o = c_s;
            COND_CC: pass_o = ~c_s;
            COND_MI: pass_o = n_s;
            COND_PL: pass_o = ~n_s;
            COND_VS: pass_o = v_s;
            COND_VC: pass_o = ~v_s;
            COND_HI: pass_o = c_s & ~z_s;
            COND_LS: pass_o = ~c_s | z_s;
            COND_GE: pass_o = (n_s == v_s);
            COND_LT: pass_o = (n_s != v_s);
            COND_GT: pass_o = ~z_s & (n_s == v_s);
            COND_LE: pass_o = z_s | (n_s != v_s);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issues ARM data-processing instructions to the ALU, one at a time:
// IDLE accepts a word, EXEC drives the ALU and decides (illegal / cond fail /
// execute), WB holds the Rd writeback until the register file accepts it.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   instr_valid/instr/instr_ready instruction handshake (ready only in IDLE)
//   rn_addr/rn_data, rm_addr/rm_data  register-file read ports
//   alu_a/alu_b/alu_opcode        ALU drive (held outside EXEC)
//   alu_c/alu_flags               ALU result and NZCV
//   wb_valid/wb_addr/wb_data/wb_ready  Rd writeback handshake
//   cpsr_flags                    current NZCV
//   illegal                       one-cycle pulse for a consumed illegal word
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rn_addr,
    input  logic [31:0] rn_data,
    output logic [3:0]  rm_addr,
    input  logic [31:0] rm_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_c,
    input  logic [3:0]  alu_flags,
    output logic        wb_valid,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic [3:0]  cpsr_flags,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  cpsr_q, cpsr_d;
    logic [3:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [4:0]  alu_op_q, alu_op_d;

    logic [3:0]  op_s;
    logic        imm_s;
    logic        s_bit_s;
    logic [3:0]  rd_s;
    logic        is_cmp_s;
    logic        is_carry_op_s;
    logic        cv_upd_s;
    logic        illegal_s;
    logic        cond_pass_s;
    logic [31:0] op2_s;
    logic [31:0] exec_a_s;
    logic [4:0]  exec_op_s;

    assign op_s    = instr_q[24:21];
    assign imm_s   = instr_q[25];
    assign s_bit_s = instr_q[20];
    assign rd_s    = instr_q[15:12];

    // TST/TEQ/CMP/CMN occupy 8..B.
    assign is_cmp_s      = (op_s[3:2] == 2'b10);
    assign is_carry_op_s = (op_s == DP_ADC) || (op_s == DP_SBC) || (op_s == DP_RSC);
    // Only the add/subtract family produces meaningful C and V.
    assign cv_upd_s      = (op_s == DP_SUB) || (op_s == DP_RSB) || (op_s == DP_ADD) ||
                           (op_s == DP_CMP) || (op_s == DP_CMN);

    // Register-shifted / shift-immediate operand2 forms are not supported.
    assign illegal_s = (instr_q[27:26] != 2'b00)
                     | is_carry_op_s
                     | (~imm_s & (instr_q[11:4] != 8'd0))
                     | (~is_cmp_s & (rd_s == 4'd15))
                     | (is_cmp_s & ~s_bit_s);

    assign op2_s     = imm_s ? ror32({24'd0, instr_q[7:0]}, {instr_q[11:8], 1'b0}) : rm_data;
    assign exec_a_s  = (op_s == DP_MOV) ? 32'd0 : rn_data;
    assign exec_op_s = map_opcode(op_s);

    cond_check u_cond_check (
        .cond_i (instr_q[31:28]),
        .nzcv_i (cpsr_q),
        .pass_o (cond_pass_s)
    );

    assign instr_ready = (state_q == IDLE);
    assign rn_addr     = instr_q[19:16];
    assign rm_addr     = instr_q[3:0];
    // Live drive during EXEC (rn/rm reads are combinational); last value otherwise.
    assign alu_a       = (state_q == EXEC) ? exec_a_s  : alu_a_q;
    assign alu_b       = (state_q == EXEC) ? op2_s     : alu_b_q;
    assign alu_opcode  = (state_q == EXEC) ? exec_op_s : alu_op_q;
    assign wb_valid    = (state_q == WB);
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign cpsr_flags  = cpsr_q;
    assign illegal     = illegal_q;

    // Next-state, flag and writeback decisions for the serial issue FSM.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        cpsr_d    = cpsr_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        illegal_d = 1'b0;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                alu_a_d  = exec_a_s;
                alu_b_d  = op2_s;
                alu_op_d = exec_op_s;
                state_d  = IDLE;
                // Illegal wins over the condition check.
                if (illegal_s) begin
                    illegal_d = 1'b1;
                end else if (cond_pass_s) begin
                    if (s_bit_s) begin
                        cpsr_d[NEG] = alu_flags[NEG];
                        cpsr_d[ZER] = alu_flags[ZER];
                        if (cv_upd_s) begin
                            cpsr_d[CAR] = alu_flags[CAR];
                            cpsr_d[OVR] = alu_flags[OVR];
                        end else begin
                            cpsr_d[CAR] = cpsr_q[CAR];
                            cpsr_d[OVR] = cpsr_q[OVR];
                        end
                    end else begin
                        cpsr_d = cpsr_q;
                    end
                    if (!is_cmp_s) begin
                        wb_addr_d = rd_s;
                        wb_data_d = alu_c;
                        state_d   = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched instruction, flags, writeback and held ALU drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            instr_q   <= 32'd0;
            cpsr_q    <= 4'd0;
            wb_addr_q <= 4'd0;
            wb_data_q <= 32'd0;
            illegal_q <= 1'b0;
            alu_a_q   <= 32'd0;
            alu_b_q   <= 32'd0;
            alu_op_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cpsr_q    <= cpsr_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
        end
    end

endmodule
